// File: rtl/updown_sweep_controller.sv
// rtl/updown_sweep_controller.sv - command-side sweep driver for a loadable up/down counter
module updown_sweep_controller #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic             abort,
    input  logic [WIDTH-1:0] count,
    output logic             load,
    output logic [WIDTH-1:0] load_value,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] start_r;
    logic [WIDTH-1:0] end_r;
    logic [WIDTH-1:0] park_r;
    logic             dir_r;
    logic             at_end;

    assign at_end    = (count == end_r);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state == LOAD) || (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            start_r <= '0;
            end_r   <= '0;
            park_r  <= '0;
            dir_r   <= 1'b1;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        start_r <= cmd_start;
                        end_r   <= cmd_end;
                        dir_r   <= (cmd_end >= cmd_start);
                        state   <= LOAD;
                    end
                end
                LOAD: state <= RUN;
                RUN: begin
                    // Reaching the end value takes priority over a simultaneous abort.
                    if (at_end) begin
                        state  <= IDLE;
                        park_r <= end_r;
                        done   <= 1'b1;
                    end else if (abort) begin
                        state   <= IDLE;
                        park_r  <= count;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The counter has no enable, so every non-stepping cycle reloads it.
    always_comb begin
        load       = 1'b1;
        load_value = park_r;
        up_down    = dir_r;
        case (state)
            LOAD: load_value = start_r;
            RUN: begin
                if (at_end) begin
                    load_value = end_r;
                end else if (abort) begin
                    load_value = count;
                end else begin
                    load       = 1'b0;
                    load_value = count;
                end
            end
            default: load_value = park_r;
        endcase
    end

endmodule

// File: tb/tb_updown_sweep_controller.sv
// tb/tb_updown_sweep_controller.sv - directed bench with a behavioural counter in the loop
module tb_updown_sweep_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start;
    logic [3:0] cmd_end;
    logic       abort;
    logic [3:0] count;
    logic       load;
    logic [3:0] load_value;
    logic       up_down;
    logic       busy;
    logic       done;
    logic       aborted;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    updown_sweep_controller #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_end    (cmd_end),
        .abort      (abort),
        .count      (count),
        .load       (load),
        .load_value (load_value),
        .up_down    (up_down),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        count <= 4'd0;
        else if (load)    count <= load_value;
        else if (up_down) count <= count + 4'd1;
        else              count <= count - 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_sweep(input logic [3:0] s, input logic [3:0] e, input int exp_edges);
        bit got_done = 0;
        int ev;
        check("cmd_ready", cmd_ready, 1);
        cmd_start = s;
        cmd_end   = e;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("load_phase_value", load_value, s);
        check("direction", up_down, (e >= s) ? 1 : 0);
        for (int k = 1; k <= 40 && !got_done; k++) begin
            tick();
            if (e >= s) ev = (int'(s) + k - 1 > int'(e)) ? int'(e) : int'(s) + k - 1;
            else        ev = (int'(s) - (k - 1) < int'(e)) ? int'(e) : int'(s) - (k - 1);
            check("count_step", count, ev);
            if (done) begin
                got_done = 1;
                check("done_edge", k, exp_edges);
                check("done_aborted", aborted, 0);
            end
        end
        if (!got_done) check("done_timeout", 0, 1);
        repeat (10) tick();
        check("hold_end", count, e);
        check("done_cleared", done, 0);
    endtask

    initial begin
        bit seen;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = 4'd0;
        cmd_end   = 4'd0;
        abort     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_count", count, 0);
            check("rst_load", load, 1);
            check("rst_ready", cmd_ready, 1);
            check("rst_done", done, 0);
        end
        check("rst_load_value", load_value, 0);
        check("rst_up_down", up_down, 1);

        run_sweep(4'd4, 4'd9, 7);
        run_sweep(4'd10, 4'd3, 9);
        run_sweep(4'd7, 4'd7, 2);

        // Abort at count 5 of a 0..15 sweep
        cmd_start = 4'd0;
        cmd_end   = 4'd15;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (count == 4'd5) seen = 1;
        end
        check("abort_reach5", seen, 1);
        abort = 1'b1;
        #1;
        check("abort_load", load, 1);
        check("abort_load_value", load_value, 5);
        tick();
        abort = 1'b0;
        check("abort_done", done, 1);
        check("abort_flag", aborted, 1);
        check("abort_count", count, 5);
        tick();
        check("abort_freeze", count, 5);
        run_sweep(4'd2, 4'd3, 3);

        // Asynchronous reset mid-sweep at count 6
        cmd_start = 4'd0;
        cmd_end   = 4'd15;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (count == 4'd6) seen = 1;
        end
        check("rst6_reach6", seen, 1);
        check("rst6_busy_before", busy, 1);
        #2;
        reset     = 1'b1;
        cmd_start = 4'd3;
        cmd_end   = 4'd5;
        cmd_valid = 1'b1;
        #1;
        check("rst6_load", load, 1);
        check("rst6_load_value", load_value, 0);
        check("rst6_busy", busy, 0);
        check("rst6_count", count, 0);
        tick();
        check("rst6_held_idle", busy, 0);
        reset = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("rst6_accept", busy, 1);
        check("rst6_load_start", load_value, 3);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (done) seen = 1;
        end
        check("rst6_done", seen, 1);
        check("rst6_final", count, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
